// File: rtl/pcm_pwm_pkg.sv
// Shared constants for the PCM-to-PWM audio DAC: default geometry and the
// saturating underrun counter used when PCM_PWM_DAC_UNDERRUN_CNT_EN is defined.
package pcm_pwm_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 4;

  localparam int                          UNDERRUN_CNT_W   = 8;
  localparam logic [UNDERRUN_CNT_W-1:0]   UNDERRUN_CNT_MAX = 8'd255;

  // Increment that sticks at the maximum instead of wrapping back to zero.
  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    logic [UNDERRUN_CNT_W-1:0] r;
    if (v == UNDERRUN_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcm_pwm_dac_sample_fifo.sv
// Sample FIFO for the PWM DAC: power-of-two depth, pointers wrap naturally,
// occupancy counter one bit wider than the pointers to tell full from empty.
module sample_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/pcm_pwm_dac.sv
// PCM-to-PWM audio DAC: buffered samples are latched per sample-rate strobe and
// applied at PWM period boundaries. Optional: PCM_PWM_DAC_UNDERRUN_CNT_EN.
module pcm_pwm_dac
  import pcm_pwm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              divide_now,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              underrun
`ifdef PCM_PWM_DAC_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              push_s;
  logic              pop_s;
  logic              pwm_wrap_s;

  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              pwm_out_q, pwm_out_d;
  logic              underrun_q, underrun_d;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign sample_ready = ~fifo_full_s;
  assign push_s       = sample_valid & ~fifo_full_s;
  assign pop_s        = divide_now & ~fifo_empty_s;
  assign pwm_wrap_s   = (pwm_cnt_q == {DATA_W{1'b1}});

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (sample_in),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  // Datapath next-state; active_d samples the pre-edge pending_q so a strobe on
  // the wrap edge only reaches the output one period later.
  always_comb begin
    pending_d  = pending_q;
    active_d   = active_q;
    pwm_cnt_d  = pwm_cnt_q + DATA_W'(1);
    pwm_out_d  = (pwm_cnt_q < active_q);
    underrun_d = divide_now & fifo_empty_s;
    if (pop_s) begin
      pending_d = fifo_head_s;
    end else begin
      pending_d = pending_q;
    end
    if (pwm_wrap_s) begin
      active_d = pending_q;
    end else begin
      active_d = active_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= {DATA_W{1'b0}};
      active_q   <= {DATA_W{1'b0}};
      pwm_cnt_q  <= {DATA_W{1'b0}};
      pwm_out_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      active_q   <= active_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_out_q  <= pwm_out_d;
      underrun_q <= underrun_d;
    end
  end

  assign pwm_out  = pwm_out_q;
  assign underrun = underrun_q;

`ifdef PCM_PWM_DAC_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  // Count advances together with the pulse it records.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d) begin
      ucnt_d = sat_inc(ucnt_q);
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= {UNDERRUN_CNT_W{1'b0}};
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: doc/pcm_pwm_dac.md
PCM_PWM_DAC -- requirements
Module: pcm_pwm_dac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, PCM sample and PWM counter width.
REQ-002 SHALL have parameter DEPTH, default 4, sample FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port divide_now  input  1  one-cycle sample-rate strobe from the sample-rate clock divider.
REQ-006 SHALL have port sample_in  input  DATA_W  unsigned PCM sample to enqueue.
REQ-007 SHALL have port sample_valid  input  1  sample_in valid this cycle.
REQ-008 SHALL have port sample_ready  output  1  FIFO can accept; equals not-full, combinational.
REQ-009 SHALL have port pwm_out  output  1  registered PWM audio output.
REQ-010 SHALL have port underrun  output  1  registered one-cycle pulse when a strobe finds the FIFO empty.

Function
REQ-011 SHALL push sample_in on a rising edge where sample_valid and sample_ready are both high; no push otherwise.
REQ-012 SHALL pop the FIFO head into pending_q on a rising edge where divide_now is high and FIFO is non-empty.
REQ-013 SHALL, on divide_now with FIFO empty, leave pending_q unchanged and pulse underrun high for the following cycle; no bypass of a same-cycle push.
REQ-014 SHALL perform push and pop in the same cycle when FIFO is neither full nor empty, occupancy unchanged.
REQ-015 SHALL deassert sample_ready when full, rejecting pushes even if a pop occurs that cycle.
REQ-016 SHALL wrap FIFO read/write pointers modulo DEPTH, with occupancy counter of width clog2(DEPTH)+1.
REQ-017 SHALL run a free-running DATA_W-bit counter pwm_cnt, 0 to 2^DATA_W-1, wrapping to 0.
REQ-018 SHALL copy pending_q into active_q only on the edge where pwm_cnt wraps from max to 0 (glitch-free period boundary).
REQ-019 SHALL register pwm_out each edge as (pwm_cnt < active_q) evaluated before that edge; 0 gives constant low, max gives high all but one cycle per period.
REQ-020 SHALL treat a strobe arriving on the wrap edge as loading pending_q only; active_q takes the old pending_q value.

Reset
REQ-021 SHALL, while rst is high, clear FIFO pointers and occupancy, pending_q, active_q, pwm_cnt, pwm_out=0, underrun=0; sample_ready=1.
REQ-022 SHALL discard all queued samples on reset asserted mid-operation; operation resumes on first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, with PCM_PWM_DAC_UNDERRUN_CNT_EN defined, add output underrun_cnt (8 bits) counting underrun pulses, saturating at 255, cleared by reset.
REQ-024 SHALL, without PCM_PWM_DAC_UNDERRUN_CNT_EN, omit underrun_cnt port and its logic; all other behaviour identical.

Structure
REQ-025 SHALL place DATA_W/DEPTH defaults and the underrun counter width/saturation constant in shared package pcm_pwm_pkg.
REQ-026 SHALL implement the FIFO as sub-module sample_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-027 SHALL cover: rst pulse mid-stream with 3 samples queued -> pwm_out=0, underrun=0, sample_ready=1, next strobe gives underrun.
REQ-028 SHALL cover: push 0x80, strobe, wait to wrap -> pwm_out high exactly 128 of the next 256 cycles.
REQ-029 SHALL cover: push 4 samples without strobe -> sample_ready=0; 5th valid ignored; strobe with simultaneous valid -> occupancy 3 (push rejected).
REQ-030 SHALL cover: strobes every 254 cycles with empty FIFO -> underrun pulse one cycle after each strobe, pwm_out holds last duty.
REQ-031 SHALL cover: push 0x00 then 0xFF -> period of constant low, then period high 255 of 256 cycles.
REQ-032 SHALL cover, with PCM_PWM_DAC_UNDERRUN_CNT_EN: 300 empty strobes -> underrun_cnt=255.
